// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: the IEEE 1149.1 state encoding and the state
// sets that enable the gated IR/DR clocks, TDO drive and the IR column.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    // One bit per encoded state; bit n set means state n belongs to the set.
    localparam logic [15:0] IR_GATE_MASK   = 16'h4400;  // CAP_IR, SH_IR
    localparam logic [15:0] DR_GATE_MASK   = 16'h0044;  // CAP_DR, SH_DR
    localparam logic [15:0] SHIFT_MASK     = 16'h0404;  // SH_IR, SH_DR
    localparam logic [15:0] IR_COLUMN_MASK = 16'h6F10;  // SEL_IR .. UPD_IR

    function automatic logic in_set(input logic [15:0] mask, input tap_state_t st);
        return mask[st];
    endfunction

endpackage

// File: rtl/tap_clock_gate.sv
// Glitch-free clock gate: enable captured by a latch that is transparent while
// clk is low, ANDed with clk; clr_n low clears the latch asynchronously.
module tap_clock_gate (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    output logic gclk
);

    logic en_l_r;

    // Enable latch, open during the low phase so the gate only changes while clk is low
    always_latch begin
        if (!clr_n) begin
            en_l_r <= 1'b0;
        end else if (!clk) begin
            en_l_r <= en;
        end
    end

    assign gclk = clk & en_l_r;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state machine, gated IR/DR clocks, update strobes
// and retimed TDO. Define TAP_STATE_OBS_EN to export the encoded state as tap_state.
`ifdef TAP_STATE_OBS_EN
module tap_state_chk
    import jtag_pkg::*;
(
    input logic       tck,
    input logic       tl_reset,
    input logic [3:0] state
);

    a_state_legal: assert property (@(posedge tck) disable iff (!tl_reset)
        state inside {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
                      UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR});

endmodule
`endif

module tap_controller
    import jtag_pkg::*;
#(
    parameter int RTI_CNT_W = 16
) (
    input  logic                 tck,
    input  logic                 tl_reset,
    input  logic                 tms,
    input  logic                 tdo_ir,
    input  logic                 tdo_dr,
    output logic                 tdo,
    output logic                 tdo_en,
    output logic                 test_logic_reset_n,
    output logic                 tck_ir,
    output logic                 captureIR,
    output logic                 updateIR,
    output logic                 tck_dr,
    output logic                 captureDR,
    output logic                 shiftDR,
    output logic                 updateDR,
    output logic                 select_ir,
    output logic [RTI_CNT_W-1:0] rti_count
`ifdef TAP_STATE_OBS_EN
    ,
    output logic [3:0]           tap_state
`endif
);

    localparam logic [RTI_CNT_W-1:0] RTI_MAX = {RTI_CNT_W{1'b1}};
    localparam logic [RTI_CNT_W-1:0] RTI_ONE = {{(RTI_CNT_W-1){1'b0}}, 1'b1};

    tap_state_t           state_r;
    tap_state_t           state_nxt_s;
    logic                 en_ir_s;
    logic                 en_dr_s;
    logic                 shift_s;
    logic                 update_ir_r;
    logic                 update_dr_r;
    logic                 tlr_n_r;
    logic                 tdo_en_r;
    logic                 tdo_r;
    logic [RTI_CNT_W-1:0] rti_count_r;

    // TAP state register
    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            state_r <= TLR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // TMS-steered next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            TLR:     state_nxt_s = tms ? TLR    : RTI;
            RTI:     state_nxt_s = tms ? SEL_DR : RTI;
            SEL_DR:  state_nxt_s = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt_s = tms ? EX1_DR : SH_DR;
            SH_DR:   state_nxt_s = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt_s = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt_s = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt_s = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt_s = tms ? SEL_DR : RTI;
            SEL_IR:  state_nxt_s = tms ? TLR    : CAP_IR;
            CAP_IR:  state_nxt_s = tms ? EX1_IR : SH_IR;
            SH_IR:   state_nxt_s = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt_s = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt_s = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt_s = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt_s = tms ? SEL_DR : RTI;
            default: state_nxt_s = TLR;
        endcase
    end

    assign captureIR = (state_r == CAP_IR);
    assign captureDR = (state_r == CAP_DR);
    assign shiftDR   = (state_r == SH_DR);
    assign select_ir = in_set(IR_COLUMN_MASK, state_r);
    assign en_ir_s   = in_set(IR_GATE_MASK, state_r);
    assign en_dr_s   = in_set(DR_GATE_MASK, state_r);
    assign shift_s   = in_set(SHIFT_MASK, state_r);

    tap_clock_gate u_gate_ir (
        .clk   (tck),
        .clr_n (tl_reset),
        .en    (en_ir_s),
        .gclk  (tck_ir)
    );

    tap_clock_gate u_gate_dr (
        .clk   (tck),
        .clr_n (tl_reset),
        .en    (en_dr_s),
        .gclk  (tck_dr)
    );

    // Falling-edge stage: update strobes, reset indication and the TDO pad
    always_ff @(negedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            update_ir_r <= 1'b0;
            update_dr_r <= 1'b0;
            tlr_n_r     <= 1'b0;
            tdo_en_r    <= 1'b0;
            tdo_r       <= 1'b0;
        end else begin
            update_ir_r <= (state_r == UPD_IR);
            update_dr_r <= (state_r == UPD_DR);
            tlr_n_r     <= (state_r != TLR);
            tdo_en_r    <= shift_s;
            // TDO only moves while a shift state drives the pad; otherwise it parks
            if (shift_s) begin
                tdo_r <= select_ir ? tdo_ir : tdo_dr;
            end else begin
                tdo_r <= tdo_r;
            end
        end
    end

    // Saturating Run-Test/Idle dwell counter
    always_ff @(posedge tck or negedge tl_reset) begin
        if (!tl_reset) begin
            rti_count_r <= {RTI_CNT_W{1'b0}};
        end else if (state_r == RTI) begin
            rti_count_r <= (rti_count_r == RTI_MAX) ? RTI_MAX : (rti_count_r + RTI_ONE);
        end else begin
            rti_count_r <= {RTI_CNT_W{1'b0}};
        end
    end

    assign updateIR           = update_ir_r;
    assign updateDR           = update_dr_r;
    assign test_logic_reset_n = tlr_n_r;
    assign tdo_en             = tdo_en_r;
    assign tdo                = tdo_r;
    assign rti_count          = rti_count_r;

`ifdef TAP_STATE_OBS_EN
    assign tap_state = state_r;

    tap_state_chk u_state_chk (
        .tck      (tck),
        .tl_reset (tl_reset),
        .state    (state_r)
    );
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed, table-driven bench for tap_controller (instantiated with RTI_CNT_W=4).
module tb_tap_controller;

    logic       tck = 1'b0;
    logic       tl_reset = 1'b0;
    logic       tms = 1'b1;
    logic       tdo_ir = 1'b0;
    logic       tdo_dr = 1'b0;
    logic       tdo, tdo_en, test_logic_reset_n, tck_ir, captureIR, updateIR;
    logic       tck_dr, captureDR, shiftDR, updateDR, select_ir;
    logic [3:0] rti_count;
`ifdef TAP_STATE_OBS_EN
    logic [3:0] tap_state;
`endif

    int checks = 0;
    int failures = 0;
    int ir_pulses = 0;
    int dr_pulses = 0;
    int upd_ir_edges = 0;
    int ir0, dr0;
    logic tdo_mid;

    tap_controller #(.RTI_CNT_W(4)) dut (
        .tck                (tck),
        .tl_reset           (tl_reset),
        .tms                (tms),
        .tdo_ir             (tdo_ir),
        .tdo_dr             (tdo_dr),
        .tdo                (tdo),
        .tdo_en             (tdo_en),
        .test_logic_reset_n (test_logic_reset_n),
        .tck_ir             (tck_ir),
        .captureIR          (captureIR),
        .updateIR           (updateIR),
        .tck_dr             (tck_dr),
        .captureDR          (captureDR),
        .shiftDR            (shiftDR),
        .updateDR           (updateDR),
        .select_ir          (select_ir),
        .rti_count          (rti_count)
`ifdef TAP_STATE_OBS_EN
        ,
        .tap_state          (tap_state)
`endif
    );

    always #5 tck = ~tck;

    always @(posedge tck_ir) ir_pulses <= ir_pulses + 1;
    always @(posedge tck_dr) dr_pulses <= dr_pulses + 1;
    always @(posedge updateIR) upd_ir_edges <= upd_ir_edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One TCK cycle: drive in the low phase, return 1 ns after the falling edge
    task automatic step(input logic t, input logic di, input logic dd);
        tms = t; tdo_ir = di; tdo_dr = dd;
        ir0 = ir_pulses; dr0 = dr_pulses;
        @(posedge tck); #1;
        tdo_mid = tdo;
        @(negedge tck); #1;
    endtask

    task automatic do_reset();
        tl_reset = 1'b0; tms = 1'b1;
        repeat (2) @(negedge tck);
        #1;
        tl_reset = 1'b1;
    endtask

    typedef struct {
        logic [7:0] path;
        int         len;
        logic       sel, cir, cdr, sdr, uir, udr, ten, tlrn;
    } st_vec_t;

    typedef struct {
        logic tms, di, dd;
        logic sel, cir, cdr, sdr, uir, udr, ten, tdo;
        int   irp, drp;
    } seq_vec_t;

    st_vec_t  sv [16];
    seq_vec_t irv [12];
    seq_vec_t drv [15];

    task automatic run_seq(input seq_vec_t v, input int idx, input logic prev_tdo);
        step(v.tms, v.di, v.dd);
        chk($sformatf("seq%0d select_ir", idx), select_ir, v.sel);
        chk($sformatf("seq%0d captureIR", idx), captureIR, v.cir);
        chk($sformatf("seq%0d captureDR", idx), captureDR, v.cdr);
        chk($sformatf("seq%0d shiftDR", idx), shiftDR, v.sdr);
        chk($sformatf("seq%0d updateIR", idx), updateIR, v.uir);
        chk($sformatf("seq%0d updateDR", idx), updateDR, v.udr);
        chk($sformatf("seq%0d tdo_en", idx), tdo_en, v.ten);
        chk($sformatf("seq%0d tdo", idx), tdo, v.tdo);
        chk($sformatf("seq%0d tdo_at_rise", idx), tdo_mid, prev_tdo);
        chk($sformatf("seq%0d tlr_n", idx), test_logic_reset_n, 1'b1);
        chk($sformatf("seq%0d ir_pulses", idx), ir_pulses - ir0, v.irp);
        chk($sformatf("seq%0d dr_pulses", idx), dr_pulses - dr0, v.drp);
    endtask

    initial begin
        // path bits are applied MSB first; fields: sel cir cdr sdr uir udr ten tlrn
        sv[0]  = '{8'b00000000, 0, 0,0,0,0, 0,0,0, 0};  // TLR
        sv[1]  = '{8'b00000000, 1, 0,0,0,0, 0,0,0, 1};  // RTI
        sv[2]  = '{8'b01000000, 2, 0,0,0,0, 0,0,0, 1};  // SelDR
        sv[3]  = '{8'b01000000, 3, 0,0,1,0, 0,0,0, 1};  // CapDR
        sv[4]  = '{8'b01000000, 4, 0,0,0,1, 0,0,1, 1};  // ShDR
        sv[5]  = '{8'b01010000, 4, 0,0,0,0, 0,0,0, 1};  // Ex1DR
        sv[6]  = '{8'b01010000, 5, 0,0,0,0, 0,0,0, 1};  // PauDR
        sv[7]  = '{8'b01010100, 6, 0,0,0,0, 0,0,0, 1};  // Ex2DR
        sv[8]  = '{8'b01011000, 5, 0,0,0,0, 0,1,0, 1};  // UpdDR
        sv[9]  = '{8'b01100000, 3, 1,0,0,0, 0,0,0, 1};  // SelIR
        sv[10] = '{8'b01100000, 4, 1,1,0,0, 0,0,0, 1};  // CapIR
        sv[11] = '{8'b01100000, 5, 1,0,0,0, 0,0,1, 1};  // ShIR
        sv[12] = '{8'b01101000, 5, 1,0,0,0, 0,0,0, 1};  // Ex1IR
        sv[13] = '{8'b01101000, 6, 1,0,0,0, 0,0,0, 1};  // PauIR
        sv[14] = '{8'b01101010, 7, 1,0,0,0, 0,0,0, 1};  // Ex2IR
        sv[15] = '{8'b01101100, 6, 1,0,0,0, 1,0,0, 1};  // UpdIR

        // IR scan: tms di dd | sel cir cdr sdr uir udr ten tdo | irp drp
        irv[0]  = '{0,0,1, 0,0,0,0,0,0,0,0, 0,0};  // RTI
        irv[1]  = '{1,0,1, 0,0,0,0,0,0,0,0, 0,0};  // SelDR
        irv[2]  = '{1,0,1, 1,0,0,0,0,0,0,0, 0,0};  // SelIR
        irv[3]  = '{0,0,1, 1,1,0,0,0,0,0,0, 0,0};  // CapIR
        irv[4]  = '{0,1,0, 1,0,0,0,0,0,1,1, 1,0};  // ShIR (capture edge)
        irv[5]  = '{0,0,1, 1,0,0,0,0,0,1,0, 1,0};  // ShIR
        irv[6]  = '{0,1,0, 1,0,0,0,0,0,1,1, 1,0};  // ShIR
        irv[7]  = '{0,1,0, 1,0,0,0,0,0,1,1, 1,0};  // ShIR
        irv[8]  = '{0,0,1, 1,0,0,0,0,0,1,0, 1,0};  // ShIR
        irv[9]  = '{1,1,0, 1,0,0,0,0,0,0,0, 1,0};  // Ex1IR (last shift edge)
        irv[10] = '{1,1,0, 1,0,0,0,1,0,0,0, 0,0};  // UpdIR
        irv[11] = '{0,1,0, 0,0,0,0,0,0,0,0, 0,0};  // RTI

        // DR scan with Pause-DR detour
        drv[0]  = '{0,1,0, 0,0,0,0,0,0,0,0, 0,0};  // RTI
        drv[1]  = '{1,1,0, 0,0,0,0,0,0,0,0, 0,0};  // SelDR
        drv[2]  = '{0,1,0, 0,0,1,0,0,0,0,0, 0,0};  // CapDR
        drv[3]  = '{0,0,1, 0,0,0,1,0,0,1,1, 0,1};  // ShDR
        drv[4]  = '{0,1,0, 0,0,0,1,0,0,1,0, 0,1};  // ShDR
        drv[5]  = '{0,0,1, 0,0,0,1,0,0,1,1, 0,1};  // ShDR
        drv[6]  = '{1,1,0, 0,0,0,0,0,0,0,1, 0,1};  // Ex1DR
        drv[7]  = '{0,1,0, 0,0,0,0,0,0,0,1, 0,0};  // PauDR
        drv[8]  = '{0,0,1, 0,0,0,0,0,0,0,1, 0,0};  // PauDR
        drv[9]  = '{0,1,0, 0,0,0,0,0,0,0,1, 0,0};  // PauDR
        drv[10] = '{1,1,0, 0,0,0,0,0,0,0,1, 0,0};  // Ex2DR
        drv[11] = '{0,1,0, 0,0,0,1,0,0,1,0, 0,0};  // ShDR
        drv[12] = '{1,0,1, 0,0,0,0,0,0,0,0, 0,1};  // Ex1DR
        drv[13] = '{1,0,1, 0,0,0,0,0,1,0,0, 0,0};  // UpdDR
        drv[14] = '{0,0,1, 0,0,0,0,0,0,0,0, 0,0};  // RTI

        // Reset values
        repeat (2) @(negedge tck);
        #1;
        chk("rst tlr_n", test_logic_reset_n, 1'b0);
        chk("rst tdo", tdo, 1'b0);
        chk("rst tdo_en", tdo_en, 1'b0);
        chk("rst updateIR", updateIR, 1'b0);
        chk("rst updateDR", updateDR, 1'b0);
        chk("rst tck_ir", tck_ir, 1'b0);
        chk("rst tck_dr", tck_dr, 1'b0);
        chk("rst rti_count", rti_count, 4'd0);
        do_reset();

        // Every state, then five TMS=1 edges back to Test-Logic-Reset
        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < sv[s].len; j++) step(sv[s].path[7-j], 1'b0, 1'b0);
            chk($sformatf("st%0d select_ir", s), select_ir, sv[s].sel);
            chk($sformatf("st%0d captureIR", s), captureIR, sv[s].cir);
            chk($sformatf("st%0d captureDR", s), captureDR, sv[s].cdr);
            chk($sformatf("st%0d shiftDR", s), shiftDR, sv[s].sdr);
            chk($sformatf("st%0d updateIR", s), updateIR, sv[s].uir);
            chk($sformatf("st%0d updateDR", s), updateDR, sv[s].udr);
            chk($sformatf("st%0d tdo_en", s), tdo_en, sv[s].ten);
            chk($sformatf("st%0d tlr_n", s), test_logic_reset_n, sv[s].tlrn);
            repeat (5) step(1'b1, 1'b0, 1'b0);
            chk($sformatf("st%0d to_tlr tlr_n", s), test_logic_reset_n, 1'b0);
            chk($sformatf("st%0d to_tlr select_ir", s), select_ir, 1'b0);
        end

        // IR scan
        do_reset();
        ir0 = ir_pulses;
        begin
            int base;
            logic prev;
            base = ir_pulses; prev = 1'b0;
            for (int i = 0; i < 12; i++) begin
                run_seq(irv[i], 100 + i, prev);
                prev = irv[i].tdo;
            end
            chk("ir total pulses", ir_pulses - base, 6);
        end

        // DR scan with pause detour
        do_reset();
        begin
            logic prev;
            prev = 1'b0;
            for (int i = 0; i < 15; i++) begin
                run_seq(drv[i], 200 + i, prev);
                prev = drv[i].tdo;
            end
        end

        // Run-Test/Idle dwell counter saturation
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("rti enter", rti_count, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("rti k=%0d", k), rti_count, (k > 15) ? 15 : k);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("rti last edge in RTI", rti_count, 4'd15);
        step(1'b0, 1'b0, 1'b0);
        chk("rti cleared", rti_count, 4'd0);

        // Reset mid-ShIR while tck is high
        do_reset();
        step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        begin
            int upd0;
            upd0 = upd_ir_edges;
            @(posedge tck); #2;
            chk("abort tck_ir before", tck_ir, 1'b1);
            tl_reset = 1'b0;
            #1;
            chk("abort tck_ir", tck_ir, 1'b0);
            chk("abort tlr_n", test_logic_reset_n, 1'b0);
            chk("abort tdo_en", tdo_en, 1'b0);
            chk("abort tdo", tdo, 1'b0);
            chk("abort select_ir", select_ir, 1'b0);
            @(negedge tck); #1;
            tl_reset = 1'b1;
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            chk("abort updateIR", updateIR, 1'b0);
            chk("abort tlr_n after", test_logic_reset_n, 1'b0);
            chk("abort rti_count", rti_count, 4'd0);
            chk("abort no update edge", upd_ir_edges - upd0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
